// File: rtl/mio_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: FSM encoding, region map
// nibbles, the bus-error read value and the latched request payload.
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mio_state_e;

    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_VGA = 4'hC;
    localparam logic [3:0] REG_KBD = 4'hD;
    localparam logic [3:0] REG_SEG = 4'hE;
    localparam logic [3:0] REG_IO  = 4'hF;

    localparam logic [31:0] BUS_ERR_RDATA = 32'h0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
    } mio_req_t;

    // Region nibble that selects a slave window.
    function automatic logic [3:0] region_of(input logic [31:0] addr);
        return addr[31:28];
    endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational slave decoder: region nibble plus optional addr[2] qualifier
// to a one-hot match vector, lowest slave index wins on overlap.
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int unsigned          N_SLV    = 6,
    parameter logic [N_SLV*4-1:0]   SLV_BASE = {REG_VGA, REG_KBD, REG_IO, REG_IO, REG_SEG, REG_RAM},
    parameter logic [N_SLV-1:0]     SLV_A2   = 6'b001100,
    parameter logic [N_SLV-1:0]     SLV_A2V  = 6'b000100
) (
    input  logic [3:0]       region,
    input  logic             a2,
    output logic [N_SLV-1:0] match,
    output logic             valid
);

    always_comb begin
        match = '0;
        valid = 1'b0;
        for (int i = 0; i < int'(N_SLV); i++) begin
            if (!valid && (region == SLV_BASE[4*i +: 4]) &&
                (!SLV_A2[i] || (a2 == SLV_A2V[i]))) begin
                match[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mio_bus_bridge.sv
// CPU data port to N-slave memory-mapped bridge: latches one request, selects
// the decoded slave until it is ready (or times out) and returns a one-cycle response.
module mio_bus_bridge
    import mio_pkg::*;
#(
    parameter int unsigned          N_SLV    = 6,
    parameter int unsigned          DW       = 32,
    parameter int unsigned          AW       = 11,
    parameter logic [N_SLV*4-1:0]   SLV_BASE = {REG_VGA, REG_KBD, REG_IO, REG_IO, REG_SEG, REG_RAM},
    parameter logic [N_SLV-1:0]     SLV_A2   = 6'b001100,
    parameter logic [N_SLV-1:0]     SLV_A2V  = 6'b000100,
    parameter int unsigned          TIMEOUT  = 15,
    parameter int unsigned          TO_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [31:0]         cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_err,
    output logic [N_SLV-1:0]    slv_sel,
    output logic                slv_we,
    output logic [AW-1:0]       slv_addr,
    output logic [DW-1:0]       slv_wdata,
    input  logic [N_SLV*DW-1:0] slv_rdata,
    input  logic [N_SLV-1:0]    slv_ready
);

    mio_state_e       state_q;
    mio_req_t         req_q;
    logic [DW-1:0]    wdata_q;
    logic [TO_W-1:0]  timer_q;

    logic [31:0]      dec_addr;
    logic [N_SLV-1:0] dec_match;
    logic             dec_valid;
    logic [DW-1:0]    tgt_rdata;
    logic             tgt_ready;
    logic [TO_W-1:0]  timer_inc;
    logic             timeout;
    logic             unused_addr_bits;

    // The live address is decoded while idle so an unmapped access can answer
    // in the next cycle; afterwards only the latched copy is used.
    always_comb begin
        dec_addr = (state_q == ST_IDLE) ? cpu_addr : req_q.addr;
    end

    assign unused_addr_bits = ^{dec_addr[27:3], dec_addr[1:0]};

    mio_addr_decode #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_A2   (SLV_A2),
        .SLV_A2V  (SLV_A2V)
    ) u_decode (
        .region (region_of(dec_addr)),
        .a2     (dec_addr[2]),
        .match  (dec_match),
        .valid  (dec_valid)
    );

    // Only the target slave's ready and read data are observed.
    always_comb begin
        tgt_rdata = '0;
        tgt_ready = 1'b0;
        for (int i = 0; i < int'(N_SLV); i++) begin
            if (dec_match[i]) begin
                tgt_rdata = slv_rdata[DW*i +: DW];
                tgt_ready = slv_ready[i];
            end
        end
    end

    assign timer_inc = timer_q + TO_W'(1);
    assign timeout   = (timer_inc == TO_W'(TIMEOUT));

    assign slv_addr  = req_q.addr[AW+1:2];
    assign slv_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            wdata_q   <= '0;
            timer_q   <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    if (cpu_req) begin
                        req_q   <= mio_req_t'{we: cpu_we, addr: cpu_addr};
                        wdata_q <= cpu_wdata;
                        if (dec_valid) begin
                            state_q <= ST_ACCESS;
                            slv_sel <= dec_match;
                            slv_we  <= cpu_we;
                            timer_q <= '0;
                        end else begin
                            state_q   <= ST_RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= DW'(BUS_ERR_RDATA);
                        end
                    end
                end

                ST_ACCESS: begin
                    // A ready in the final allowed cycle still completes cleanly.
                    if (tgt_ready) begin
                        state_q   <= ST_RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b0;
                        cpu_rdata <= req_q.we ? '0 : tgt_rdata;
                        slv_sel   <= '0;
                        slv_we    <= 1'b0;
                        timer_q   <= '0;
                    end else if (timeout) begin
                        state_q   <= ST_RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= DW'(BUS_ERR_RDATA);
                        slv_sel   <= '0;
                        slv_we    <= 1'b0;
                        timer_q   <= TO_W'(TIMEOUT);
                    end else begin
                        timer_q   <= timer_inc;
                    end
                end

                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    slv_sel   <= '0;
                    slv_we    <= 1'b0;
                    timer_q   <= '0;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    slv_sel   <= '0;
                    slv_we    <= 1'b0;
                    timer_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Bench for mio_bus_bridge: table of single transactions against a slave model
// with configurable wait states, a response scoreboard, and hand-written reset
// and back-to-back sequences.
module tb_mio_bus_bridge;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic          cpu_err;
    logic [5:0]    slv_sel;
    logic          slv_we;
    logic [10:0]   slv_addr;
    logic [31:0]   slv_wdata;
    logic [191:0]  slv_rdata;
    logic [5:0]    slv_ready;

    mio_bus_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] srdata;
        int          waits;
        logic [5:0]  noise;
        logic        drop;
        logic [5:0]  exp_sel;
        logic [10:0] exp_saddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          start;
        int          id;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   waits_cfg = -1;
    logic [5:0] noise_cfg = 6'b0;
    int   acc_cnt;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[12];

    // Slave model: the selected slave answers after waits_cfg wait states;
    // noise_cfg raises ready on slaves that are not selected.
    always @(posedge clk or negedge rst) begin
        if (!rst)            acc_cnt <= 0;
        else if (slv_sel != 6'b0) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
    end

    assign slv_ready = (((waits_cfg >= 0) && (acc_cnt == waits_cfg)) ? slv_sel : 6'b0)
                     | (noise_cfg & ~slv_sel);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Response scoreboard.
    always @(negedge clk) begin
        if (rst && cpu_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("rdata_%0d", mon_e.id), cpu_rdata, mon_e.rdata);
                check($sformatf("err_%0d", mon_e.id), {31'b0, cpu_err}, {31'b0, mon_e.err});
                check($sformatf("latency_%0d", mon_e.id), 32'(cyc - mon_e.start), 32'(mon_e.lat));
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        logic [5:0] sel_or;
        int         sel_cyc;
        int         bad;
        logic       got;
        waits_cfg = v.waits;
        noise_cfg = v.noise;
        for (int i = 0; i < 6; i++)
            slv_rdata[32*i +: 32] = v.exp_sel[i] ? v.srdata : ~v.srdata;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_req   = 1'b1;
        exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_cyc, start: cyc, id: idx});
        sel_or  = 6'b0;
        sel_cyc = 0;
        bad     = 0;
        got     = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (slv_sel != 6'b0) begin
                sel_or  = sel_or | slv_sel;
                sel_cyc++;
                if (slv_sel !== v.exp_sel || slv_addr !== v.exp_saddr ||
                    slv_wdata !== v.wdata || slv_we !== v.we)
                    bad++;
                if (v.drop && sel_cyc == 1) begin
                    cpu_req   = 1'b0;
                    cpu_addr  = 32'hFFFF_FFFF;
                    cpu_wdata = 32'h0;
                end
            end
            if (cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        check($sformatf("ready_seen_%0d", idx), {31'b0, got}, 32'd1);
        if (!got) exp_q.delete();
        check($sformatf("sel_%0d", idx), {26'b0, sel_or}, {26'b0, v.exp_sel});
        check($sformatf("sel_cycles_%0d", idx), 32'(sel_cyc),
              (v.exp_sel != 6'b0) ? 32'(v.exp_cyc - 1) : 32'd0);
        check($sformatf("bus_stable_%0d", idx), 32'(bad), 32'd0);
        @(negedge clk);
        check($sformatf("ready_pulse_%0d", idx), {31'b0, cpu_ready}, 32'd0);
        check($sformatf("sel_idle_%0d", idx), {26'b0, slv_sel}, 32'd0);
    endtask

    initial begin
        vec_t r;
        logic got;

        //          we    addr           wdata          srdata       waits noise     drop  sel        saddr    rdata         err   cyc
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678,  0, 6'b000000, 1'b0, 6'b000001, 11'h004, 32'h1234_5678, 1'b0,  2};
        vecs[1]  = '{1'b1, 32'hF000_0004, 32'h0000_00A5, 32'hDEAD_BEEF,  3, 6'b000000, 1'b0, 6'b000100, 11'h001, 32'h0000_0000, 1'b0,  5};
        vecs[2]  = '{1'b0, 32'hF000_0000, 32'h0000_0000, 32'hCAFE_0001,  1, 6'b000100, 1'b0, 6'b001000, 11'h000, 32'hCAFE_0001, 1'b0,  3};
        vecs[3]  = '{1'b0, 32'h5000_0000, 32'h0000_0000, 32'h0BAD_0BAD,  0, 6'b000000, 1'b0, 6'b000000, 11'h000, 32'h0000_0000, 1'b1,  1};
        vecs[4]  = '{1'b0, 32'hD000_0000, 32'h0000_0000, 32'h2468_ACE0, 14, 6'b000000, 1'b0, 6'b010000, 11'h000, 32'h2468_ACE0, 1'b0, 16};
        vecs[5]  = '{1'b0, 32'hD000_0000, 32'h0000_0000, 32'h1357_9BDF, -1, 6'b000000, 1'b0, 6'b010000, 11'h000, 32'h0000_0000, 1'b1, 16};
        vecs[6]  = '{1'b0, 32'hC000_07FC, 32'h0000_0000, 32'h7777_0001,  2, 6'b011111, 1'b0, 6'b100000, 11'h1FF, 32'h7777_0001, 1'b0,  4};
        vecs[7]  = '{1'b1, 32'hE000_0008, 32'h5A5A_5A5A, 32'h8888_0002,  0, 6'b000000, 1'b0, 6'b000010, 11'h002, 32'h0000_0000, 1'b0,  2};
        vecs[8]  = '{1'b0, 32'hF000_0004, 32'h0000_0000, 32'h9999_0003,  0, 6'b001000, 1'b0, 6'b000100, 11'h001, 32'h9999_0003, 1'b0,  2};
        vecs[9]  = '{1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 32'hAAAA_0004,  0, 6'b000000, 1'b0, 6'b000000, 11'h000, 32'h0000_0000, 1'b1,  1};
        vecs[10] = '{1'b0, 32'h0000_1FFC, 32'h0000_0000, 32'hBBBB_0005,  4, 6'b000000, 1'b1, 6'b000001, 11'h7FF, 32'hBBBB_0005, 1'b0,  6};
        vecs[11] = '{1'b0, 32'h0000_2010, 32'h0000_0000, 32'hCCCC_0006,  0, 6'b000000, 1'b0, 6'b000001, 11'h004, 32'hCCCC_0006, 1'b0,  2};

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        slv_rdata = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_ready", {31'b0, cpu_ready}, 32'h0);
        check("rst_err", {31'b0, cpu_err}, 32'h0);
        check("rst_sel", {26'b0, slv_sel}, 32'h0);
        check("rst_we", {31'b0, slv_we}, 32'h0);
        check("rst_saddr", {21'b0, slv_addr}, 32'h0);
        check("rst_wdata", slv_wdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        repeat (3) @(negedge clk);
        check("rdata_hold", cpu_rdata, vecs[11].exp_rdata);

        // Asynchronous reset while a keyboard read is waiting on its slave.
        waits_cfg = -1;
        noise_cfg = 6'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'hD000_0000;
        cpu_req   = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_access_sel", {26'b0, slv_sel}, {26'b0, 6'b010000});
        cpu_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_sel", {26'b0, slv_sel}, 32'h0);
        check("async_rst_ready", {31'b0, cpu_ready}, 32'h0);
        check("async_rst_err", {31'b0, cpu_err}, 32'h0);
        check("async_rst_we", {31'b0, slv_we}, 32'h0);
        @(negedge clk);
        check("async_rst_rdata", cpu_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        r = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0F0F_1234, 1, 6'b000000, 1'b0,
              6'b000001, 11'h010, 32'h0F0F_1234, 1'b0, 3};
        run_vec(20, r);

        // Back-to-back reads with cpu_req held high across both.
        waits_cfg = 0;
        noise_cfg = 6'b0;
        slv_rdata = '0;
        slv_rdata[31:0]  = 32'h1111_1111;
        slv_rdata[63:32] = 32'h2222_2222;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0020;
        cpu_req  = 1'b1;
        exp_q.push_back('{rdata: 32'h1111_1111, err: 1'b0, lat: 2, start: cyc, id: 100});
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cpu_ready) got = 1'b1;
        end
        check("b2b_first_seen", {31'b0, got}, 32'd1);
        cpu_addr = 32'hE000_0000;
        exp_q.push_back('{rdata: 32'h2222_2222, err: 1'b0, lat: 3, start: cyc, id: 101});
        @(negedge clk);
        check("b2b_gap_ready", {31'b0, cpu_ready}, 32'h0);
        check("b2b_gap_sel", {26'b0, slv_sel}, 32'h0);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        check("b2b_second_seen", {31'b0, got}, 32'd1);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
